ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 24'd1_000_000, prefix-abandon timeout in clk_sys cycles.
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port kbd_int  input  1  one-cycle pulse; kbd_scan valid.
REQ-005 SHALL have port kbd_scan  input  8  raw PS/2 set-2 byte from the PS/2 receiver.
REQ-006 SHALL have port ps2_key  output  11  key event: [10] strobe toggle, [9] pressed, [8] extended, [7:0] code.
REQ-007 SHALL have port osd_o  output  8  level vector of OSD navigation keys.

Function
REQ-008 SHALL decode bytes with FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (after E1).
REQ-009 IDLE: E0->EXT, F0->BRK, E1->PAUSE; AA, FA, FE, EE, 00, FF SHALL be dropped; any other byte emits a make event {pressed=1, extended=0}.
REQ-010 EXT: F0->EXT_BRK; E0 stays in EXT; 12 or 59 (fake shift) SHALL be dropped -> IDLE; other bytes emit {1,1,code} -> IDLE.
REQ-011 BRK: byte emits {0,0,code} -> IDLE; EXT_BRK: 12/59 dropped, else emits {0,1,code} -> IDLE.
REQ-012 PAUSE: 3-bit counter SHALL consume exactly 7 further bytes unconditionally, then emit {1,1,8'h77} -> IDLE.
REQ-013 Emission: ps2_key[9:0] SHALL update and ps2_key[10] toggle on the clk_sys edge after the kbd_int cycle of the final byte (latency 1); ps2_key SHALL otherwise hold.
REQ-014 Dropped bytes SHALL neither toggle ps2_key[10] nor modify ps2_key[9:0].
REQ-015 A 24-bit idle counter SHALL clear on every kbd_int and increment otherwise, saturating at TIMEOUT_CYCLES.
REQ-016 In EXT, BRK, EXT_BRK or PAUSE, counter reaching TIMEOUT_CYCLES with no kbd_int SHALL force IDLE with no emission; a kbd_int on that same cycle SHALL take priority and be decoded normally.
REQ-017 Back-to-back kbd_int pulses on consecutive cycles SHALL each be decoded; no byte SHALL be lost.

Reset
REQ-018 reset_n low SHALL asynchronously force state IDLE, ps2_key=11'h000, osd_o=8'h00, idle and PAUSE counters=0.
REQ-019 kbd_int asserted while reset_n is low SHALL be ignored; reset mid-prefix SHALL discard the partial sequence.
REQ-020 First event after reset release SHALL set ps2_key[10]=1.

Configuration
REQ-021 Macro OSD_KEYS_EN SHALL, when defined, drive osd_o as levels set on make and cleared on break: [0] right E0 74, [1] left E0 6B, [2] down E0 72, [3] up E0 75, [4] enter 5A, [5] esc 76, [6] F12 07, [7] space 29.
REQ-022 OSD bits SHALL update on the same edge as the ps2_key emission and match the extended flag exactly (non-extended 74 SHALL NOT set bit 0).
REQ-023 Without OSD_KEYS_EN, osd_o SHALL be constant 8'h00 and no OSD logic SHALL be synthesized; ps2_key behaviour SHALL be identical.

Verification
REQ-024 Bytes 1C, F0 1C -> ps2_key 0x61C then 0x01C (strobe toggles twice; first event 10'h21C with strobe=1).
REQ-025 Bytes E0 75, E0 F0 75 with OSD_KEYS_EN -> ps2_key[9:0] 0x375 then 0x175; osd_o 8'h08 then 8'h00.
REQ-026 Bytes E0 12 E0 7C (PrtScr make) -> exactly one event {1,1,7C}; fake shift dropped, strobe toggles once.
REQ-027 Bytes E1 14 77 E1 F0 14 F0 77 -> single event {1,1,77} after eighth byte; no event before.
REQ-028 Byte E0, then no kbd_int for TIMEOUT_CYCLES (set 100 in bench), then 1C -> event {1,0,1C}, not extended.
REQ-029 Byte F0, reset_n pulsed low, then 1C -> ps2_key=0x000 during reset, then {1,0,1C} with strobe=1.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Keyboard-byte to key-event bus for ps2_key_decoder.
// Handshake: kbd_int is a one-cycle valid for kbd_scan with no ready, so the decoder accepts
// every pulse. Each new event toggles ps2_key[10]. osd_o holds levels and state_dbg shows the decoder state.
interface ps2_key_decoder_if;
  logic        kbd_int;
  logic [7:0]  kbd_scan;
  logic [10:0] ps2_key;
  logic [7:0]  osd_o;
  logic [2:0]  state_dbg;

  modport master (output kbd_int, kbd_scan, input ps2_key, osd_o, state_dbg);
  modport slave  (input kbd_int, kbd_scan, output ps2_key, osd_o, state_dbg);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: turns raw bytes into toggle-strobed key events.
// Optional OSD navigation key levels on osd_o when OSD_KEYS_EN is defined.
module ps2_key_decoder #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input logic               clk_sys,
  input logic               reset_n,
  ps2_key_decoder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  pause_cnt, pause_nx;
  logic [23:0] idle_cnt;
  logic [10:0] key_q;
  logic        emit;
  logic        ev_pressed;
  logic        ev_ext;
  logic [7:0]  ev_code;

  always_comb begin
    state_nx   = state;
    pause_nx   = pause_cnt;
    emit       = 1'b0;
    ev_pressed = 1'b0;
    ev_ext     = 1'b0;
    ev_code    = bus.kbd_scan;
    if (bus.kbd_int) begin
      case (state)
        S_IDLE: begin
          case (bus.kbd_scan)
            8'hE0: state_nx = S_EXT;
            8'hF0: state_nx = S_BRK;
            8'hE1: begin
              state_nx = S_PAUSE;
              pause_nx = 3'd0;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_nx = S_IDLE;
            default: begin
              emit       = 1'b1;
              ev_pressed = 1'b1;
            end
          endcase
        end
        S_EXT: begin
          case (bus.kbd_scan)
            8'hF0: state_nx = S_EXT_BRK;
            8'hE0: state_nx = S_EXT;
            // Fake shifts wrapped around extended keys carry no key information.
            8'h12, 8'h59: state_nx = S_IDLE;
            default: begin
              emit       = 1'b1;
              ev_pressed = 1'b1;
              ev_ext     = 1'b1;
              state_nx   = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          emit     = 1'b1;
          state_nx = S_IDLE;
        end
        S_EXT_BRK: begin
          state_nx = S_IDLE;
          if (bus.kbd_scan != 8'h12 && bus.kbd_scan != 8'h59) begin
            emit   = 1'b1;
            ev_ext = 1'b1;
          end
        end
        S_PAUSE: begin
          // Pause/Break sends E1 plus seven fixed bytes; only the count matters.
          if (pause_cnt == 3'd6) begin
            emit       = 1'b1;
            ev_pressed = 1'b1;
            ev_ext     = 1'b1;
            ev_code    = 8'h77;
            state_nx   = S_IDLE;
          end else begin
            pause_nx = pause_cnt + 3'd1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end else if (state != S_IDLE && idle_cnt == TIMEOUT_CYCLES) begin
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pause_cnt <= 3'd0;
      idle_cnt  <= 24'd0;
      key_q     <= 11'h000;
    end else begin
      state     <= state_nx;
      pause_cnt <= pause_nx;
      if (bus.kbd_int)
        idle_cnt <= 24'd0;
      else if (idle_cnt != TIMEOUT_CYCLES)
        idle_cnt <= idle_cnt + 24'd1;
      if (emit)
        key_q <= {~key_q[10], ev_pressed, ev_ext, ev_code};
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.state_dbg = state;

`ifdef OSD_KEYS_EN
  logic [7:0] osd_q;
  logic       osd_hit;
  logic [2:0] osd_idx;

  // The extended flag is part of the match so keypad twins do not alias arrows.
  always_comb begin
    osd_hit = 1'b1;
    osd_idx = 3'd0;
    case ({ev_ext, ev_code})
      9'h174:  osd_idx = 3'd0;
      9'h16B:  osd_idx = 3'd1;
      9'h172:  osd_idx = 3'd2;
      9'h175:  osd_idx = 3'd3;
      9'h05A:  osd_idx = 3'd4;
      9'h076:  osd_idx = 3'd5;
      9'h007:  osd_idx = 3'd6;
      9'h029:  osd_idx = 3'd7;
      default: osd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      osd_q <= 8'h00;
    else if (emit && osd_hit)
      osd_q[osd_idx] <= ev_pressed;
  end

  assign bus.osd_o = osd_q;
`else
  assign bus.osd_o = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scan-code sequences plus random byte streams
// checked against a prefix-flag reference model.
module tb_ps2_key_decoder;

  localparam logic [23:0] T = 24'd100;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  ps2_key_decoder_if bus_if();

  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Scoreboard entry: {cycle[31:0], osd[7:0], key[10:0]}
  logic [50:0] exp_q[$];
  bit          m_ext, m_brk, m_pause;
  int          m_pause_left;
  logic [10:0] m_key;
  logic [7:0]  m_osd;
  int unsigned last_int_cyc;

  function automatic int osd_bit(input bit e, input logic [7:0] c);
    case ({e, c})
      9'h174: return 0;
      9'h16B: return 1;
      9'h172: return 2;
      9'h175: return 3;
      9'h05A: return 4;
      9'h076: return 5;
      9'h007: return 6;
      9'h029: return 7;
      default: return -1;
    endcase
  endfunction

  task automatic model_emit(input bit p, input bit e, input logic [7:0] c, input int unsigned at);
    int idx;
    m_key = {~m_key[10], p, e, c};
`ifdef OSD_KEYS_EN
    idx = osd_bit(e, c);
    if (idx >= 0) m_osd[idx] = p;
`else
    idx = -1;
`endif
    exp_q.push_back({at[31:0], m_osd, m_key});
  endtask

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_pause = 0; m_pause_left = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input int unsigned gap, input int unsigned at);
    if ((m_ext || m_brk || m_pause) && gap > T) model_clear();
    if (m_pause) begin
      m_pause_left--;
      if (m_pause_left == 0) begin
        model_clear();
        model_emit(1, 1, 8'h77, at);
      end
    end else if (m_brk) begin
      if (!(m_ext && (b == 8'h12 || b == 8'h59))) model_emit(0, m_ext, b, at);
      model_clear();
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'h12 || b == 8'h59) model_clear();
      else begin
        model_clear();
        model_emit(1, 1, b, at);
      end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_brk = 1;
        8'hE1: begin m_pause = 1; m_pause_left = 7; end
        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
        default: model_emit(1, 0, b, at);
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned at;
    if (gap > 0) begin
      @(posedge clk_sys); #1;
      bus_if.kbd_int = 1'b0;
      repeat (gap - 1) @(posedge clk_sys);
    end
    @(posedge clk_sys); #1;
    bus_if.kbd_int  = 1'b1;
    bus_if.kbd_scan = b;
    at = cyc + 1;
    model_byte(b, at - last_int_cyc - 1, at);
    last_int_cyc = at;
  endtask

  task automatic idle(input int unsigned n);
    @(posedge clk_sys); #1;
    bus_if.kbd_int = 1'b0;
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #1;
    bus_if.kbd_int = 1'b0;
    reset_n = 1'b0;
    #2;
    check("reset_key", {21'd0, bus_if.ps2_key}, 32'h000);
    check("reset_osd", {24'd0, bus_if.osd_o}, 32'h00);
    check("reset_state", {29'd0, bus_if.state_dbg}, 32'd0);
    check("reset_queue_empty", exp_q.size(), 0);
    // A byte presented during reset must be ignored.
    @(posedge clk_sys); #1;
    bus_if.kbd_int  = 1'b1;
    bus_if.kbd_scan = 8'h1C;
    @(posedge clk_sys); #1;
    bus_if.kbd_int = 1'b0;
    check("reset_hold_key", {21'd0, bus_if.ps2_key}, 32'h000);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    model_clear();
    m_key = 11'h000;
    m_osd = 8'h00;
    last_int_cyc = cyc;
  endtask

  // ---------------- monitor ----------------
  logic [10:0] prev_key = 11'h000;
  logic [7:0]  prev_osd = 8'h00;

  always @(negedge clk_sys) begin
    logic [50:0] e;
    if (!reset_n) begin
      prev_key = bus_if.ps2_key;
      prev_osd = bus_if.osd_o;
    end else begin
      if (bus_if.ps2_key[10] != prev_key[10]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {21'd0, bus_if.ps2_key}, {21'd0, prev_key});
        end else begin
          e = exp_q.pop_front();
          check("event_key", {21'd0, bus_if.ps2_key}, {21'd0, e[10:0]});
          check("event_osd", {24'd0, bus_if.osd_o}, {24'd0, e[18:11]});
          check("event_cycle", cyc, e[50:19]);
        end
      end else begin
        check("hold_key", {21'd0, bus_if.ps2_key}, {21'd0, prev_key});
        check("hold_osd", {24'd0, bus_if.osd_o}, {24'd0, prev_osd});
      end
      prev_key = bus_if.ps2_key;
      prev_osd = bus_if.osd_o;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] osd_codes[8];
    logic [7:0] drops[6];
    osd_codes = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h5A, 8'h76, 8'h07, 8'h29};
    drops     = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    r = $urandom_range(0, 99);
    if (r < 12) return 8'hE0;
    if (r < 22) return 8'hF0;
    if (r < 24) return 8'hE1;
    if (r < 29) return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
    if (r < 34) return drops[$urandom_range(0, 5)];
    if (r < 52) return osd_codes[$urandom_range(0, 7)];
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic int unsigned rand_gap();
    int r;
    r = $urandom_range(0, 19);
    if (r < 11) return 0;
    if (r < 18) return $urandom_range(1, 4);
    return $urandom_range(95, 110);
  endfunction

  initial begin
    logic [7:0] osd_up;
`ifdef OSD_KEYS_EN
    osd_up = 8'h08;
`else
    osd_up = 8'h00;
`endif
    bus_if.kbd_int  = 1'b0;
    bus_if.kbd_scan = 8'h00;
    m_key = 11'h000;
    m_osd = 8'h00;
    model_clear();
    last_int_cyc = 0;
    repeat (3) @(posedge clk_sys);
    do_reset();

    send_byte(8'h1C, 2);
    idle(3);
    check("make_1c", {21'd0, bus_if.ps2_key}, 32'h61C);
    send_byte(8'hF0, 1); send_byte(8'h1C, 0);
    idle(3);
    check("break_1c", {21'd0, bus_if.ps2_key}, 32'h01C);

    send_byte(8'hE0, 1); send_byte(8'h75, 0);
    idle(3);
    check("make_up", {21'd0, bus_if.ps2_key}, 32'h775);
    check("osd_up_make", {24'd0, bus_if.osd_o}, {24'd0, osd_up});
    send_byte(8'hE0, 1); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    idle(3);
    check("break_up", {21'd0, bus_if.ps2_key}, 32'h175);
    check("osd_up_break", {24'd0, bus_if.osd_o}, 32'h00);

    send_byte(8'hE0, 1); send_byte(8'h12, 0); send_byte(8'hE0, 0); send_byte(8'h7C, 0);
    idle(3);
    check("prtscr", {21'd0, bus_if.ps2_key}, 32'h77C);

    send_byte(8'hE1, 1); send_byte(8'h14, 0); send_byte(8'h77, 1); send_byte(8'hE1, 0);
    send_byte(8'hF0, 2); send_byte(8'h14, 0); send_byte(8'hF0, 0);
    idle(2);
    check("pause_no_early", {21'd0, bus_if.ps2_key}, 32'h77C);
    send_byte(8'h77, 0);
    idle(3);
    check("pause", {21'd0, bus_if.ps2_key}, 32'h377);

    send_byte(8'hE0, 1);
    send_byte(8'h1C, 110);
    idle(3);
    check("timeout_abandon", {21'd0, bus_if.ps2_key}, 32'h61C);
    send_byte(8'hE0, 1);
    send_byte(8'h1C, 50);
    idle(3);
    check("no_timeout", {21'd0, bus_if.ps2_key}, 32'h31C);

    send_byte(8'hF0, 1);
    idle(2);
    do_reset();
    send_byte(8'h1C, 2);
    idle(3);
    check("after_reset", {21'd0, bus_if.ps2_key}, 32'h61C);

    for (int i = 0; i < 400; i++) send_byte(rand_byte(), rand_gap());
    idle(3);
    do_reset();
    for (int i = 0; i < 200; i++) send_byte(rand_byte(), rand_gap());
    idle(5);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
